// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - MIPS-style execute ALU with iterative mult/div and HI/LO registers
// Single-cycle ops resolve at acceptance; mult/div iterate WIDTH cycles in MUL/DIV.
module alu_exec #(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic             islog,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cond,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [1:0] {K_ONE, K_MUL, K_DIV, K_DIVZ} kind_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] ml;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] result_r;
    logic             cond_r;
    logic             ill_r;
    logic             out_valid_r;

    kind_t            d_kind;
    logic [WIDTH-1:0] d_res;
    logic             d_cond;
    logic             d_ill;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_neg;
    logic             a_zero;

    always_comb begin
        d_kind = K_ONE;
        d_res  = '0;
        d_cond = 1'b0;
        d_ill  = 1'b0;
        sum    = a + b;
        diff   = a - b;
        a_neg  = a[WIDTH-1];
        a_zero = (a == '0);
        case (aluop)
            2'b10: begin
                case (funct)
                    6'b100000: d_res = sum;
                    6'b100010: d_res = diff;
                    6'b100100: d_res = a & b;
                    6'b100101: d_res = a | b;
                    6'b100111: d_res = ~(a | b);
                    6'b101010: d_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'b011000: begin
                        if (MD_EN) d_kind = K_MUL;
                        else       d_ill  = 1'b1;
                    end
                    6'b011010: begin
                        if (MD_EN) d_kind = (b == '0) ? K_DIVZ : K_DIV;
                        else       d_ill  = 1'b1;
                    end
                    6'b010000: begin
                        if (MD_EN) d_res = hi_r;
                        else       d_ill = 1'b1;
                    end
                    6'b010010: begin
                        if (MD_EN) d_res = lo_r;
                        else       d_ill = 1'b1;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            2'b01: begin
                d_res  = diff;
                d_cond = (a == b);
            end
            2'b00: begin
                // Branch compares are signed against zero; only bne returns a value.
                case (funct[3:0])
                    4'b1000: d_res = sum;
                    4'b1100: d_res = a & b;
                    4'b1101: d_res = a | b;
                    4'b0101: begin
                        d_res  = diff;
                        d_cond = (a != b);
                    end
                    4'b0001: d_cond = islog ? ~a_neg : a_neg;
                    4'b0111: d_cond = ~a_neg & ~a_zero;
                    4'b0110: d_cond = a_neg | a_zero;
                    default: d_ill = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
    end

    // One shift-add or restoring-subtract step per cycle on {acc, ml}.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_n;
    logic [WIDTH-1:0] mul_ml_n;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc_n;
    logic [WIDTH-1:0] div_ml_n;

    always_comb begin
        mul_sum   = {1'b0, acc} + (ml[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_acc_n = mul_sum[WIDTH:1];
        mul_ml_n  = {mul_sum[0], ml[WIDTH-1:1]};
        div_sh    = {acc, ml[WIDTH-1]};
        div_sub   = div_sh - {1'b0, opnd};
        div_ge    = (div_sh >= {1'b0, opnd});
        div_acc_n = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_ml_n  = {ml[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            ml          <= '0;
            opnd        <= '0;
            hi_r        <= '0;
            lo_r        <= '0;
            result_r    <= '0;
            cond_r      <= 1'b0;
            ill_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        case (d_kind)
                            K_MUL: begin
                                acc   <= '0;
                                ml    <= b;
                                opnd  <= a;
                                state <= MUL;
                            end
                            K_DIV: begin
                                acc   <= '0;
                                ml    <= a;
                                opnd  <= b;
                                state <= DIV;
                            end
                            K_DIVZ: begin
                                hi_r        <= a;
                                lo_r        <= '1;
                                result_r    <= '1;
                                cond_r      <= 1'b0;
                                ill_r       <= 1'b0;
                                out_valid_r <= 1'b1;
                                state       <= DONE;
                            end
                            default: begin
                                result_r    <= d_res;
                                cond_r      <= d_cond;
                                ill_r       <= d_ill;
                                out_valid_r <= 1'b1;
                                state       <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc <= mul_acc_n;
                    ml  <= mul_ml_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        hi_r        <= mul_acc_n;
                        lo_r        <= mul_ml_n;
                        result_r    <= mul_ml_n;
                        cond_r      <= 1'b0;
                        ill_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_acc_n;
                    ml  <= div_ml_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        hi_r        <= div_acc_n;
                        lo_r        <= div_ml_n;
                        result_r    <= div_ml_n;
                        cond_r      <= 1'b0;
                        ill_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cond      = cond_r;
    assign illegal   = ill_r;
    assign hi        = MD_EN ? hi_r : '0;
    assign lo        = MD_EN ? lo_r : '0;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec (WIDTH=32, MD_EN=1)
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        islog;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cond;
    logic        illegal;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    alu_exec #(.WIDTH(32), .MD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .islog(islog), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cond(cond), .illegal(illegal), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency, check outputs, then handshake if out_ready is high.
    task automatic run(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic il, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] er, input logic ec, input logic ei, input int el);
        int lat;
        check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        aluop = op; funct = fn; islog = il; a = va; b = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(el));
        check({tag, "_res"}, {32'd0, result}, {32'd0, er});
        check({tag, "_cond"}, {63'd0, cond}, {63'd0, ec});
        check({tag, "_ill"}, {63'd0, illegal}, {63'd0, ei});
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; aluop = 2'b00; funct = 6'd0; islog = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", {63'd0, in_ready}, 64'd1);

        run("slt",   2'b10, 6'b101010, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 1);
        run("addw",  2'b10, 6'b100000, 0, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 0, 1);
        run("sub",   2'b10, 6'b100010, 0, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 1);
        run("and",   2'b10, 6'b100100, 0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 0, 0, 1);
        run("nor",   2'b10, 6'b100111, 0, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 0, 0, 1);
        run("beq",   2'b01, 6'b000000, 0, 32'd5, 32'd5, 32'd0, 1, 0, 1);
        run("bne",   2'b00, 6'b000101, 0, 32'd7, 32'd3, 32'd4, 1, 0, 1);
        run("iadd",  2'b00, 6'b001000, 0, 32'd10, 32'd20, 32'd30, 0, 0, 1);
        run("bgez",  2'b00, 6'b000001, 1, 32'h8000_0000, 32'd9, 32'd0, 0, 0, 1);
        run("bltz",  2'b00, 6'b000001, 0, 32'h8000_0000, 32'd9, 32'd0, 1, 0, 1);
        run("blez",  2'b00, 6'b000110, 0, 32'd0, 32'd9, 32'd0, 1, 0, 1);
        run("bgtz",  2'b00, 6'b000111, 0, 32'd1, 32'd9, 32'd0, 1, 0, 1);
        run("ill11", 2'b11, 6'b100000, 0, 32'd1, 32'd2, 32'd0, 0, 1, 1);
        run("illr",  2'b10, 6'b000000, 0, 32'd1, 32'd2, 32'd0, 0, 1, 1);

        run("mult",  2'b10, 6'b011000, 0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0, 0, 33);
        check("mult_hi", {32'd0, hi}, 64'd1);
        check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFE);
        run("mfhi",  2'b10, 6'b010000, 0, 32'd0, 32'd0, 32'd1, 0, 0, 1);
        run("mflo",  2'b10, 6'b010010, 0, 32'd0, 32'd0, 32'hFFFF_FFFE, 0, 0, 1);
        run("div",   2'b10, 6'b011010, 0, 32'd100, 32'd7, 32'd14, 0, 0, 33);
        check("div_hi", {32'd0, hi}, 64'd2);
        check("div_lo", {32'd0, lo}, 64'd14);
        run("div0",  2'b10, 6'b011010, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, 1);
        check("div0_hi", {32'd0, hi}, 64'd5);
        check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);

        out_ready = 1'b0;
        run("hold",  2'b10, 6'b100101, 0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; aluop = 2'b10; funct = 6'b100000;
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_ovalid", {63'd0, out_valid}, 64'd1);
            check("hold_res", {32'd0, result}, 64'h0000_00FF);
            check("hold_rdy", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_ovalid", {63'd0, out_valid}, 64'd0);
        check("hs_rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        check("hs_noqueue", {63'd0, out_valid}, 64'd0);

        aluop = 2'b10; funct = 6'b011000; a = 32'd3; b = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_rdy", {63'd0, in_ready}, 64'd1);
        check("mrst_ovalid", {63'd0, out_valid}, 64'd0);
        check("mrst_hilo", {hi, lo}, 64'd0);
        #2;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mrst_idle_ovalid", {63'd0, out_valid}, 64'd0);
        check("mrst_idle_hilo", {hi, lo}, 64'd0);
        run("postrst", 2'b10, 6'b100000, 0, 32'd40, 32'd2, 32'd42, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
